// File: rtl/acc_stage.sv
// Batch accumulator: sums COUNT unsigned N-bit operands, then holds the sum and a
// sticky carry flag until downstream takes it. Define ACC_SATURATE_EN to clamp on carry.
module acc_stage #(
  parameter int N     = 6,
  parameter int COUNT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_ovf,
  output logic [0:0]   dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready/out_valid come straight from the state register, so neither side sees a
  // combinational path through this block.

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  localparam int CW = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  logic [0:0]    state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          accept;
  logic [N:0]    sum;
  logic [N-1:0]  acc_next;

  assign accept = in_valid && (state_q == ST_ACCUM);
  assign sum    = {1'b0, acc_q} + {1'b0, in_data};

`ifdef ACC_SATURATE_EN
  // Once clamped, any further non-zero add carries again, so acc stays at all ones.
  assign acc_next = sum[N] ? {N{1'b1}} : sum[N-1:0];
`else
  assign acc_next = sum[N-1:0];
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_ACCUM: begin
        if (accept) begin
          acc_d = acc_next;
          if (sum[N]) ovf_d = 1'b1;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = ST_HOLD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready    = (state_q == ST_ACCUM);
  assign out_valid   = (state_q == ST_HOLD);
  assign out_data    = acc_q;
  assign out_ovf     = ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_acc_stage.sv
// Self-checking bench for acc_stage (N=6, COUNT=4): vector table, corner-case
// sequences and random batches scored against a sum-of-operands model.
module tb_acc_stage;

  localparam int N     = 6;
  localparam int COUNT = 4;
  localparam int MAXV  = (1 << N) - 1;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_ovf;
  logic [0:0]   dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [N:0] exp_q[$];

  acc_stage #(.N(N), .COUNT(COUNT)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_ovf     (out_ovf),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, act, exp);
  endtask

  // Model: the result depends only on the batch's arithmetic total.
  function automatic logic [N:0] model(input int total);
    logic [N-1:0] d;
    logic         o;
    o = (total > MAXV);
`ifdef ACC_SATURATE_EN
    d = o ? N'(MAXV) : N'(total);
`else
    d = N'(total % (MAXV + 1));
`endif
    return {o, d};
  endfunction

  // driver tasks: entered and left on a falling edge
  task automatic send(input logic [N-1:0] v);
    int t;
    in_valid = 1'b1;
    in_data  = v;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom_range(0, MAXV);
  endtask

  task automatic collect(input string name, input logic [N:0] exp);
    int t;
    out_ready = 1'b1;
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_valid"}, int'(out_valid), 1);
    chk({name, "_data"}, int'(out_data), int'(exp[N-1:0]));
    chk({name, "_ovf"}, int'(out_ovf), int'(exp[N]));
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_ready_back"}, int'(in_ready), 1);
  endtask

  typedef struct {
    logic [N-1:0] a, b, c, d;
    logic [N-1:0] exp_data;
    logic         exp_ovf;
    string        name;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [N-1:0] held;
    logic [N:0]   e;
    int           total;
    logic [N-1:0] op;

`ifdef ACC_SATURATE_EN
    vecs[0] = '{6'd3,  6'd5,  6'd7,  6'd9,  6'd24, 1'b0, "v_3579"};
    vecs[1] = '{6'd20, 6'd20, 6'd20, 6'd20, 6'd63, 1'b1, "v_20x4"};
    vecs[2] = '{6'd1,  6'd2,  6'd3,  6'd4,  6'd10, 1'b0, "v_1234"};
    vecs[3] = '{6'd63, 6'd1,  6'd0,  6'd0,  6'd63, 1'b1, "v_63100"};
    vecs[4] = '{6'd2,  6'd2,  6'd2,  6'd2,  6'd8,  1'b0, "v_2x4"};
    vecs[5] = '{6'd63, 6'd63, 6'd63, 6'd63, 6'd63, 1'b1, "v_63x4"};
    vecs[6] = '{6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  1'b0, "v_zero"};
    vecs[7] = '{6'd32, 6'd31, 6'd0,  6'd1,  6'd63, 1'b1, "v_edge64"};
`else
    vecs[0] = '{6'd3,  6'd5,  6'd7,  6'd9,  6'd24, 1'b0, "v_3579"};
    vecs[1] = '{6'd20, 6'd20, 6'd20, 6'd20, 6'd16, 1'b1, "v_20x4"};
    vecs[2] = '{6'd1,  6'd2,  6'd3,  6'd4,  6'd10, 1'b0, "v_1234"};
    vecs[3] = '{6'd63, 6'd1,  6'd0,  6'd0,  6'd0,  1'b1, "v_63100"};
    vecs[4] = '{6'd2,  6'd2,  6'd2,  6'd2,  6'd8,  1'b0, "v_2x4"};
    vecs[5] = '{6'd63, 6'd63, 6'd63, 6'd63, 6'd60, 1'b1, "v_63x4"};
    vecs[6] = '{6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  1'b0, "v_zero"};
    vecs[7] = '{6'd32, 6'd31, 6'd0,  6'd1,  6'd0,  1'b1, "v_edge64"};
`endif

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_ovf", int'(out_ovf), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // vector table, operands on consecutive cycles, checks 1-cycle latency
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].a);
      send(vecs[i].b);
      send(vecs[i].c);
      chk({vecs[i].name, "_not_early"}, int'(out_valid), 0);
      send(vecs[i].d);
      chk({vecs[i].name, "_latency"}, int'(out_valid), 1);
      chk({vecs[i].name, "_in_ready_low"}, int'(in_ready), 0);
      collect(vecs[i].name, {vecs[i].exp_ovf, vecs[i].exp_data});
    end

    // backpressure with in_valid held high
    send(6'd3); send(6'd5); send(6'd7); send(6'd9);
    held = out_data;
    in_valid = 1'b1;
    in_data  = 6'd7;
    for (int c = 0; c < 5; c++) begin
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_data_stable", int'(out_data), int'(held));
      @(negedge clk);
    end
    in_valid = 1'b0;
    collect("bp_result", {1'b0, 6'd24});
    send(6'd1); send(6'd1); send(6'd1); send(6'd1);
    collect("bp_next", {1'b0, 6'd4});

    // gaps between operands
    send(6'd1); @(negedge clk);
    send(6'd2); @(negedge clk); @(negedge clk);
    send(6'd3); @(negedge clk);
    send(6'd4);
    collect("gaps", {1'b0, 6'd10});

    // asynchronous reset mid-batch
    send(6'd10); send(6'd10);
    #2 rst = 1'b1;
    #1;
    chk("amid_in_ready", int'(in_ready), 1);
    chk("amid_out_valid", int'(out_valid), 0);
    chk("amid_out_data", int'(out_data), 0);
    chk("amid_out_ovf", int'(out_ovf), 0);
    @(negedge clk);
    rst = 1'b0;
    send(6'd1); send(6'd1); send(6'd1); send(6'd1);
    collect("rst_mid", {1'b0, 6'd4});

    // asynchronous reset while holding a result
    send(6'd40); send(6'd40); send(6'd1); send(6'd1);
    #2 rst = 1'b1;
    #1;
    chk("ahold_out_valid", int'(out_valid), 0);
    chk("ahold_out_ovf", int'(out_ovf), 0);
    @(negedge clk);
    rst = 1'b0;
    send(6'd5); send(6'd6); send(6'd7); send(6'd8);
    collect("rst_hold", {1'b0, 6'd26});

    // back-to-back with out_ready tied high
    out_ready = 1'b1;
    send(6'd63); send(6'd1); send(6'd0); send(6'd0);
    chk("b2b1_valid", int'(out_valid), 1);
    e = model(64);
    chk("b2b1_data", int'(out_data), int'(e[N-1:0]));
    chk("b2b1_ovf", int'(out_ovf), 1);
    @(negedge clk);
    chk("b2b_no_bypass", int'(out_valid), 0);
    send(6'd2); send(6'd2); send(6'd2); send(6'd2);
    chk("b2b2_valid", int'(out_valid), 1);
    chk("b2b2_data", int'(out_data), 8);
    chk("b2b2_ovf", int'(out_ovf), 0);
    @(negedge clk);
    out_ready = 1'b0;

    // random batches against the model
    for (int b = 0; b < 40; b++) begin
      total = 0;
      for (int k = 0; k < COUNT; k++) begin
        op = (($urandom_range(0, 3) == 0) ? N'(MAXV) : N'($urandom_range(0, MAXV)));
        total += int'(op);
        send(op);
        for (int g = $urandom_range(0, 2); g > 0; g--) @(negedge clk);
      end
      exp_q.push_back(model(total));
      for (int s = $urandom_range(0, 3); s > 0; s--) begin
        chk("rnd_hold_valid", int'(out_valid), 1);
        @(negedge clk);
      end
      collect("rnd", exp_q.pop_front());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
